// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, bypass select encodings and the pipeline-stage record for hazard_ctrl.
// Tnew/Tuse widths and the "never read" Tuse code live here so every stage agrees on them.
package hazard_ctrl_pkg;

  localparam int T_W = 3;
  localparam logic [T_W-1:0] NO_USE = T_W'(7);

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic [4:0]     waddr;
    logic [T_W-1:0] tnew;
    logic [4:0]     raddr0;
    logic [4:0]     raddr1;
  } stage_t;

  // Tnew counts down by one per stage and parks at zero once the result exists.
  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bundle between the pipeline (master) and hazard_ctrl (slave).
// HAZARD_MDU_STALL_EN adds the multiply/divide busy handshake signals.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_ctrl_pkg::*;

  logic [4:0]       d_raddr0;
  logic [4:0]       d_raddr1;
  logic [T_W-1:0]   d_tuse0;
  logic [T_W-1:0]   d_tuse1;
  logic [4:0]       d_waddr;
  logic [T_W-1:0]   d_tnew;
  logic             stall;
  logic             e_flush;
  logic [1:0]       fwd_d_rs;
  logic [1:0]       fwd_d_rt;
  logic [1:0]       fwd_e_rs;
  logic [1:0]       fwd_e_rt;
  logic             fwd_m_rt;
  logic [CNT_W-1:0] stall_cnt;
`ifdef HAZARD_MDU_STALL_EN
  logic             d_use_mdu;
  logic             e_md_start;
  logic             md_busy;
`endif

`ifdef HAZARD_MDU_STALL_EN
  modport master (
    output d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
    output d_use_mdu, e_md_start, md_busy,
    input  stall, e_flush, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );
  modport slave (
    input  d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
    input  d_use_mdu, e_md_start, md_busy,
    output stall, e_flush, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );
`else
  modport master (
    output d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
    input  stall, e_flush, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );
  modport slave (
    input  d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
    output stall, e_flush, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );
`endif

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Bypass select for one operand: picks the youngest enabled stage (E, M, W) whose
// destination matches and whose result already exists; otherwise the register value.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter logic [2:0] SRC_EN = 3'b111
) (
  input  logic [4:0]          addr,
  input  logic [2:0][4:0]     src_waddr,
  input  logic [2:0][T_W-1:0] src_tnew,
  output logic [1:0]          sel
);

  logic [2:0] ok;

  // Index 0 = E, 1 = M, 2 = W; $0 is never a forwarding target.
  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    assign ok[gi] = SRC_EN[gi] && (addr != '0) && (src_waddr[gi] == addr) && (src_tnew[gi] == '0);
  end

  always_comb begin
    sel = FWD_RF;
    if (ok[2]) sel = FWD_W;
    if (ok[1]) sel = FWD_M;
    if (ok[0]) sel = FWD_E;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward scheduler for the 5-stage MIPS pipeline: shadows (addr, Tnew) through E/M/W,
// raises stall on unresolvable RAW hazards and drives all bypass selects. HAZARD_MDU_STALL_EN
// additionally stalls MDU consumers while the multiply/divide unit is busy or starting.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave hif
);

  stage_t           e_reg;
  stage_t           e_next;
  stage_t           d_rec;
  logic [4:0]       m_waddr_reg;
  logic [T_W-1:0]   m_tnew_reg;
  logic [4:0]       m_raddr1_reg;
  logic [4:0]       w_waddr_reg;
  logic [T_W-1:0]   w_tnew_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_next;

  logic             stall;
  logic             mdu_stall;
  logic [1:0]       port_stall;
  logic [4:0]       d_raddr [2];
  logic [T_W-1:0]   d_tuse  [2];

  assign d_rec.waddr  = hif.d_waddr;
  assign d_rec.tnew   = hif.d_tnew;
  assign d_rec.raddr0 = hif.d_raddr0;
  assign d_rec.raddr1 = hif.d_raddr1;

  assign d_raddr[0] = hif.d_raddr0;
  assign d_raddr[1] = hif.d_raddr1;
  assign d_tuse[0]  = hif.d_tuse0;
  assign d_tuse[1]  = hif.d_tuse1;

  // A D-stage read must wait while a matching E/M producer still needs more cycles than
  // the reader can spare; W results always exist, so W never stalls.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic hit_e;
    logic hit_m;
    assign hit_e = (d_raddr[gi] != '0) && (d_raddr[gi] == e_reg.waddr);
    assign hit_m = (d_raddr[gi] != '0) && (d_raddr[gi] == m_waddr_reg);
    assign port_stall[gi] = (d_tuse[gi] != NO_USE) &&
                            ((hit_e && (d_tuse[gi] < e_reg.tnew)) ||
                             (hit_m && (d_tuse[gi] < m_tnew_reg)));
  end

`ifdef HAZARD_MDU_STALL_EN
  assign mdu_stall = hif.d_use_mdu && (hif.md_busy || hif.e_md_start);
`else
  assign mdu_stall = 1'b0;
`endif

  assign stall = (|port_stall) || mdu_stall;

  always_comb begin
    e_next = '0;
    if (!stall) e_next = d_rec;
  end

  assign stall_cnt_next = stall ? stall_cnt_reg + CNT_W'(1) : stall_cnt_reg;

  // M and W keep draining during a stall; only E takes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_reg         <= '0;
      m_waddr_reg   <= '0;
      m_tnew_reg    <= '0;
      m_raddr1_reg  <= '0;
      w_waddr_reg   <= '0;
      w_tnew_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      e_reg         <= e_next;
      m_waddr_reg   <= e_reg.waddr;
      m_tnew_reg    <= sat_dec(e_reg.tnew);
      m_raddr1_reg  <= e_reg.raddr1;
      w_waddr_reg   <= m_waddr_reg;
      w_tnew_reg    <= sat_dec(m_tnew_reg);
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Operands: 0 D.rs, 1 D.rt, 2 E.rs, 3 E.rt, 4 M.rt (store data). Later stages may only
  // take values from stages older than themselves.
  logic [2:0][4:0]     src_waddr;
  logic [2:0][T_W-1:0] src_tnew;
  logic [4:0]          op_addr [5];
  logic [1:0]          op_sel  [5];

  assign src_waddr = {w_waddr_reg, m_waddr_reg, e_reg.waddr};
  assign src_tnew  = {w_tnew_reg, m_tnew_reg, e_reg.tnew};

  assign op_addr[0] = hif.d_raddr0;
  assign op_addr[1] = hif.d_raddr1;
  assign op_addr[2] = e_reg.raddr0;
  assign op_addr[3] = e_reg.raddr1;
  assign op_addr[4] = m_raddr1_reg;

  for (genvar gi = 0; gi < 5; gi++) begin : g_fwd
    localparam logic [2:0] SRC_EN = (gi < 2) ? 3'b111 : ((gi < 4) ? 3'b110 : 3'b100);
    hazard_ctrl_fwd_sel #(
      .SRC_EN (SRC_EN)
    ) u_fwd_sel (
      .addr      (op_addr[gi]),
      .src_waddr (src_waddr),
      .src_tnew  (src_tnew),
      .sel       (op_sel[gi])
    );
  end

  assign hif.stall     = stall;
  assign hif.e_flush   = stall;
  assign hif.fwd_d_rs  = op_sel[0];
  assign hif.fwd_d_rt  = op_sel[1];
  assign hif.fwd_e_rs  = op_sel[2];
  assign hif.fwd_e_rt  = op_sel[3];
  assign hif.fwd_m_rt  = (op_sel[4] == FWD_W);
  assign hif.stall_cnt = stall_cnt_reg;

endmodule
